cp_issue_queue: RTL and testbench
=================================

# cp_issue_queue

Instruction issue buffer for the coprocessor, directly upstream of the coprocessor control unit. It accepts 32-bit coprocessor instructions from the main core over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It presents one instruction per cycle to the decode/control stage, with bits [31:26] driven as that stage's 6-bit opcode. It drops illegal opcodes and inserts a configurable interlock after memory-load instructions.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- LOAD_STALL, 1, bubble cycles inserted after issuing a load (opcode 6'b110011); 0 disables the interlock
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  core offers in_instr
- in_instr  in  32  instruction word, opcode in [31:26]
- in_ready  out  1  queue can accept this cycle
- flush  in  1  synchronous discard of all queued/pending state
- issue_ready  in  1  downstream stage accepts this cycle
- issue_valid  out  1  issue_instr is a legal instruction to issue
- issue_instr  out  32  head instruction; 32'h0 when issue_valid = 0
- opcode  out  6  issue_instr[31:26], feeds the control unit
- count  out  $clog2(DEPTH)+1  occupied entries
- illegal_op  out  1  one-cycle pulse, the cycle after an illegal head is dropped

## Operation
- Legal opcodes: 6'b10???? (ALU-immediate class) and 6'b110000–6'b110100. All others are illegal.
- Push: in_valid & in_ready. in_ready = (count < DEPTH) & ~flush.
  - in_ready is taken from the registered count, so a full queue does not accept a push even in a cycle where it pops.
- Head is legal and stall_cnt == 0 → issue_valid = 1. Pop on issue_valid & issue_ready.
- Head is illegal → auto-pop the same cycle, regardless of issue_ready or stall_cnt.
  - issue_valid stays 0 for that entry.
  - illegal_op = 1 on the next cycle only.
- Issuing opcode 6'b110011 loads stall_cnt ← LOAD_STALL. While stall_cnt ≠ 0:
  - issue_valid = 0 and illegal heads are not dropped.
  - stall_cnt decrements by 1 per cycle, saturating at 0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Flush, asserted for one cycle:
  - Next cycle: rd_ptr = wr_ptr = 0, count = 0, stall_cnt = 0, illegal_op = 0.
  - A push offered in the flush cycle is refused (in_ready = 0).
  - issue_valid is forced 0 in the flush cycle.
- Reset, rst_n low at a clock edge: same effect as flush. It also clears illegal_op, and is legal at any point mid-stream.
  - Storage array is not reset.
  - Outputs after reset: in_ready 1, issue_valid 0, issue_instr 0, opcode 0, count 0, illegal_op 0.
- While issue_valid = 0, issue_instr and opcode are 0. Opcode 6'b000000 decodes to all-zero control, so a bubble is a no-op downstream.

## Timing
- Push-to-issue latency: 1 cycle. An entry written at edge N can show issue_valid in the cycle after edge N.
- Throughput: 1 issue per cycle, except during load interlocks.
- issue_valid, issue_instr and opcode are combinational from registered head, count and stall_cnt, plus flush. issue_valid must not depend on issue_ready.
- Load bubbles: load issued at edge N; issue_valid = 0 for exactly LOAD_STALL cycles after it; the next issue can occur at edge N+LOAD_STALL+1.
- Illegal drop costs one cycle per illegal entry.
- count, pointers and stall_cnt update on rising edge only.

## Test plan
- Reset then stream: push 8'd... sequence 32'h8000_0001, 32'hC000_0002, 32'hC400_0003 with issue_ready = 1 → issued in order, one per cycle, first issue 1 cycle after first push; count peaks at 1.
- Fill/full (DEPTH = 4): issue_ready = 0, push 5 words → in_ready = 0 after 4th, count = 4, 5th held by core. Raise issue_ready and push in the same cycle → pop occurs, push refused that cycle, accepted next.
- Load interlock, LOAD_STALL = 2: queue 32'hCC00_0000 (opcode 110011) then 32'h8000_0000 → load issues at N, issue_valid low N+1..N+2, ALU issue at N+3. Repeat with LOAD_STALL = 0 → back-to-back.
- Illegal drop: queue 32'h0400_0000 (opcode 000001), 32'hD400_0000 (110101), 32'h8000_0000 → two silent drops, illegal_op pulses on two consecutive cycles, then 8000_0000 issues; count ends 0.
- Flush/reset mid-operation: 3 entries queued, stall_cnt = 1, assert flush with in_valid = 1 → next cycle count = 0, issue_valid = 0, stall_cnt = 0, pushed word lost. Repeat with rst_n = 0 → same outputs, illegal_op cleared.
- Wrap-around: 10 push/pop pairs at full rate with random legal opcodes → scoreboard matches in order; pointers wrap at least twice.

Source files
------------

// File: rtl/cp_issue_queue.sv
// Coprocessor issue queue: buffers core instructions, drops illegal opcodes, bubbles after loads.
// Latency 1 cycle push-to-issue; in_ready falls when full (registered count) or flushing.

module cp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module cp_issue_queue #(
  parameter int DEPTH      = 4,
  parameter int LOAD_STALL = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [31:0]            in_instr,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic                   issue_ready,
  output logic                   issue_valid,
  output logic [31:0]            issue_instr,
  output logic [5:0]             opcode,
  output logic [$clog2(DEPTH):0] count,
  output logic                   illegal_op
);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int STALL_W = (LOAD_STALL < 1) ? 1 : $clog2(LOAD_STALL + 1);
  localparam logic [CNT_W-1:0]   FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [STALL_W-1:0] STALL_INIT = STALL_W'(LOAD_STALL);
  localparam logic [5:0]         OP_LOAD    = 6'b110011;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [25:0] body;
  } instr_t;

  function automatic logic is_legal(input logic [5:0] op);
    return (op[5:4] == 2'b10) || ((op >= 6'b110000) && (op <= 6'b110100));
  endfunction

  instr_t             head;
  logic [CNT_W-1:0]   fifo_count;
  logic [STALL_W-1:0] stall_cnt;
  logic               head_vld;
  logic               head_legal;
  logic               stalled;
  logic               drop;
  logic               issue_fire;
  logic               push;
  logic               pop;

  cp_fifo #(
    .WIDTH ($bits(instr_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .push     (push),
    .push_dat (in_instr),
    .pop      (pop),
    .head_dat (head),
    .count    (fifo_count)
  );

  assign head_vld   = (fifo_count != '0);
  assign head_legal = is_legal(head.opcode);
  assign stalled    = (stall_cnt != '0);

  // Illegal heads are held, not dropped, while a load interlock is running.
  assign issue_valid = head_vld & head_legal & ~stalled & ~flush;
  assign drop        = head_vld & ~head_legal & ~stalled & ~flush;
  assign issue_fire  = issue_valid & issue_ready;
  assign pop         = issue_fire | drop;

  assign in_ready = (fifo_count < FULL_CNT) & ~flush;
  assign push     = in_valid & in_ready;

  assign issue_instr = issue_valid ? head : '0;
  assign opcode      = issue_instr[31:26];
  assign count       = fifo_count;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      stall_cnt <= '0;
    end else if (issue_fire && (head.opcode == OP_LOAD)) begin
      stall_cnt <= STALL_INIT;
    end else if (stalled) begin
      stall_cnt <= stall_cnt - STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= drop;
    end
  end
endmodule

// File: tb/tb_cp_issue_queue.sv
// Directed bench for cp_issue_queue: one instance with a 2-cycle load interlock, one with none.
module tb_cp_issue_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        flush;
  logic        issue_ready;

  logic        in_ready,    in_ready_ns;
  logic        issue_valid, issue_valid_ns;
  logic [31:0] issue_instr, issue_instr_ns;
  logic [5:0]  opcode,      opcode_ns;
  logic [2:0]  count,       count_ns;
  logic        illegal_op,  illegal_op_ns;

  int n_cmp = 0;
  int n_err = 0;

  cp_issue_queue #(.DEPTH(4), .LOAD_STALL(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .issue_ready(issue_ready),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .opcode(opcode),
    .count(count), .illegal_op(illegal_op)
  );

  cp_issue_queue #(.DEPTH(4), .LOAD_STALL(0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready_ns), .flush(flush), .issue_ready(issue_ready),
    .issue_valid(issue_valid_ns), .issue_instr(issue_instr_ns), .opcode(opcode_ns),
    .count(count_ns), .illegal_op(illegal_op_ns)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; issue_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] s_words [3];
  logic [31:0] w [10];
  logic [31:0] body;
  logic [5:0]  op;
  int          r;

  initial begin
    s_words[0] = 32'h8000_0001;
    s_words[1] = 32'hC000_0002;
    s_words[2] = 32'hC400_0003;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst in_ready",    32'(in_ready),    32'd1);
    chk("rst issue_valid", 32'(issue_valid), 32'd0);
    chk("rst issue_instr", issue_instr,      32'h0);
    chk("rst opcode",      32'(opcode),      32'd0);
    chk("rst count",       32'(count),       32'd0);
    chk("rst illegal_op",  32'(illegal_op),  32'd0);
    tick();

    // Streaming with issue_ready high: each word issues the cycle after its push
    issue_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k < 3);
      in_instr = '0;
      if (k < 3) in_instr = s_words[k];
      @(negedge clk);
      if (k == 0 || k == 4) begin
        chk("stream idle valid", 32'(issue_valid), 32'd0);
        chk("stream idle count", 32'(count), 32'd0);
      end else begin
        chk("stream valid", 32'(issue_valid), 32'd1);
        chk("stream instr", issue_instr, s_words[k-1]);
        chk("stream count", 32'(count), 32'd1);
      end
      tick();
    end

    // Fill to full, then pop in a cycle where a push is refused
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_instr = 32'h8000_0010 + 32'(k);
      @(negedge clk);
      chk("fill in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_instr    = 32'h8000_0014;
    issue_ready = 1'b1;
    @(negedge clk);
    chk("full count",    32'(count),    32'd4);
    chk("full in_ready", 32'(in_ready), 32'd0);
    chk("full head",     issue_instr,   32'h8000_0010);
    tick();
    issue_ready = 1'b0;
    @(negedge clk);
    chk("after pop count",    32'(count),    32'd3);
    chk("after pop in_ready", 32'(in_ready), 32'd1);
    chk("after pop head",     issue_instr,   32'h8000_0011);
    tick();
    in_valid    = 1'b0;
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) chk("refill count", 32'(count), 32'd4);
      chk("drain instr", issue_instr, 32'h8000_0011 + 32'(k));
      tick();
    end
    @(negedge clk);
    chk("drain count", 32'(count), 32'd0);
    chk("drain valid", 32'(issue_valid), 32'd0);

    // Load interlock: LOAD_STALL=2 instance bubbles, LOAD_STALL=0 instance does not
    do_reset();
    in_valid = 1'b1;
    in_instr = 32'hCC00_0000;
    tick();
    in_instr = 32'h8000_0000;
    tick();
    in_valid    = 1'b0;
    issue_ready = 1'b1;
    @(negedge clk);
    chk("ld valid",     32'(issue_valid),    32'd1);
    chk("ld opcode",    32'(opcode),         32'h33);
    chk("ld ns valid",  32'(issue_valid_ns), 32'd1);
    tick();
    @(negedge clk);
    chk("ld bubble1 valid",  32'(issue_valid),    32'd0);
    chk("ld bubble1 instr",  issue_instr,         32'h0);
    chk("ld bubble1 opcode", 32'(opcode),         32'd0);
    chk("ld ns b2b valid",   32'(issue_valid_ns), 32'd1);
    chk("ld ns b2b instr",   issue_instr_ns,      32'h8000_0000);
    tick();
    @(negedge clk);
    chk("ld bubble2 valid", 32'(issue_valid),    32'd0);
    chk("ld ns empty",      32'(issue_valid_ns), 32'd0);
    tick();
    @(negedge clk);
    chk("ld alu valid", 32'(issue_valid), 32'd1);
    chk("ld alu instr", issue_instr,      32'h8000_0000);
    tick();
    @(negedge clk);
    chk("ld end count", 32'(count), 32'd0);

    // Illegal drops
    do_reset();
    in_valid = 1'b1;
    in_instr = 32'h0400_0000;
    tick();
    in_instr = 32'hD400_0000;
    @(negedge clk);
    chk("ill1 valid", 32'(issue_valid), 32'd0);
    chk("ill1 count", 32'(count),       32'd1);
    chk("ill1 pulse", 32'(illegal_op),  32'd0);
    tick();
    in_instr = 32'h8000_0000;
    @(negedge clk);
    chk("ill2 pulse", 32'(illegal_op),  32'd1);
    chk("ill2 valid", 32'(issue_valid), 32'd0);
    chk("ill2 count", 32'(count),       32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("ill3 pulse", 32'(illegal_op),  32'd1);
    chk("ill3 valid", 32'(issue_valid), 32'd1);
    chk("ill3 instr", issue_instr,      32'h8000_0000);
    tick();
    @(negedge clk);
    chk("ill4 pulse", 32'(illegal_op), 32'd0);
    chk("ill4 count", 32'(count),      32'd1);
    issue_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("ill end count", 32'(count), 32'd0);

    // Flush mid-operation with the load interlock running
    do_reset();
    in_valid = 1'b1;
    in_instr = 32'hCC00_0000;
    tick();
    for (int k = 1; k < 4; k++) begin
      in_instr = 32'h8000_0000 + 32'(k);
      tick();
    end
    in_valid    = 1'b0;
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    tick();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h8000_00FF;
    @(negedge clk);
    chk("fl pre stall",    32'(dut.stall_cnt),  32'd1);
    chk("fl pre count",    32'(count),          32'd3);
    chk("fl in_ready",     32'(in_ready),       32'd0);
    chk("fl ns valid",     32'(issue_valid_ns), 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl count",    32'(count),          32'd0);
    chk("fl valid",    32'(issue_valid),    32'd0);
    chk("fl stall",    32'(dut.stall_cnt),  32'd0);
    chk("fl in_ready", 32'(in_ready),       32'd1);
    chk("fl ns count", 32'(count_ns),       32'd0);
    tick();

    // Reset mid-operation clears a pending illegal pulse and refuses the push
    do_reset();
    in_valid = 1'b1;
    in_instr = 32'h0400_0000;
    tick();
    rst_n    = 1'b0;
    in_instr = 32'h8000_0005;
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mrst illegal_op",  32'(illegal_op),  32'd0);
    chk("mrst count",       32'(count),       32'd0);
    chk("mrst issue_valid", 32'(issue_valid), 32'd0);
    chk("mrst issue_instr", issue_instr,      32'h0);
    chk("mrst in_ready",    32'(in_ready),    32'd1);
    tick();

    // Wrap-around at full rate with random legal non-load opcodes
    for (int k = 0; k < 10; k++) begin
      r = $urandom_range(0, 19);
      case (r)
        16:      op = 6'b110000;
        17:      op = 6'b110001;
        18:      op = 6'b110010;
        19:      op = 6'b110100;
        default: op = {2'b10, r[3:0]};
      endcase
      body = $urandom;
      w[k] = {op, body[25:0]};
    end
    do_reset();
    issue_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      in_valid = (k < 10);
      in_instr = '0;
      if (k < 10) in_instr = w[k];
      @(negedge clk);
      if (k > 0) begin
        chk("wrap instr", issue_instr, w[k-1]);
        chk("wrap count", 32'(count),  32'd1);
      end else begin
        chk("wrap start count", 32'(count), 32'd0);
      end
      tick();
    end
    @(negedge clk);
    chk("wrap end count", 32'(count),              32'd0);
    chk("wrap wr_ptr",    32'(dut.u_fifo.wr_ptr),  32'd2);
    chk("wrap rd_ptr",    32'(dut.u_fifo.rd_ptr),  32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
